wb_port_master: RTL
===================

// Module: wb_port_master
// PURPOSE
//  Pipelined Wishbone B4 initiator for one port (A or B) of memory_top.
//  Converts a simple valid/ready command stream into bus cycles, honours STALL.
//  Tracks outstanding requests; returns ACKed data in order. Watchdog aborts a hung cycle.
//  Sits between a core/DMA client and memory_top; one instance per port.
// PARAMETERS
//  MAX_OUTSTANDING  4    max accepted-but-unACKed requests (1..15)
//  TIMEOUT          64   cycles without ACK (while outstanding>0) before abort (>=2)
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  rst        in   1   reset, asynchronous, active-low
//  cmd_valid  in   1   client request valid
//  cmd_ready  out  1   request accepted when cmd_valid & cmd_ready
//  cmd_we     in   1   1=write, 0=read
//  cmd_addr   in   8   word address
//  cmd_data   in   32  write data
//  cmd_sel    in   4   byte select
//  rsp_valid  out  1   one-cycle pulse per completed request (no backpressure)
//  rsp_data   out  32  read data (write completions: captured DATA_I, don't care)
//  err        out  1   one-cycle pulse on timeout abort or ACK with none outstanding
//  CYC_O      out  1   Wishbone cycle
//  STB_O      out  1   Wishbone strobe
//  WE_O       out  1   Wishbone write enable
//  ADDR_O     out  8   Wishbone address
//  DATA_O     out  32  Wishbone write data
//  SEL_O      out  4   Wishbone byte select
//  STALL_I    in   1   slave cannot accept this cycle
//  ACK_I      in   1   slave completion
//  DATA_I     in   32  slave read data, valid with ACK_I
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0; outstanding count 0; watchdog 0; request reg empty.
//  Request reg: holds one pending beat driving STB/WE/ADDR/DATA/SEL. Bus accept = STB_O & ~STALL_I.
//  cmd_ready = (~STB_O | ~STALL_I) & (outstanding + STB_O < MAX_OUTSTANDING) & ~abort; combinational.
//  On cmd handshake: reg loads cmd_* next edge, STB_O=1. Else on bus accept: STB_O=0.
//  STB_O never drops and WE/ADDR/DATA/SEL never change while STB_O & STALL_I (hold rule).
//  Back-to-back: accept and new load in same cycle -> STB_O stays 1, one beat per clock.
//  Outstanding: +1 on bus accept, -1 on ACK_I & CYC_O; both same cycle -> unchanged.
//  CYC_O = 1 from the first STB_O cycle until outstanding=0 and STB_O=0; registered.
//  States: IDLE (CYC_O=0) -> BUSY on first cmd handshake; BUSY -> IDLE when drained;
//    BUSY -> ABORT on watchdog expiry; ABORT (1 cycle: CYC_O=STB_O=0, count cleared, err=1) -> IDLE.
//  Response: rsp_valid=1, rsp_data=DATA_I registered, 1 cycle after ACK_I & CYC_O. Latency accept->rsp
//    = slave ACK latency + 1.
//  ACK_I while CYC_O=0 or outstanding=0: ignored for rsp; err pulses next cycle.
//  Watchdog: counts cycles with outstanding>0 and no ACK_I; reset by any ACK; at TIMEOUT -> ABORT.
//    Pending unaccepted STB beat is discarded on abort; no rsp for aborted requests.
//  Reset mid-cycle: bus drops immediately (async), all in-flight requests lost, no rsp/err emitted.
//  Count width = $clog2(MAX_OUTSTANDING+1); never exceeds MAX_OUTSTANDING, never underflows.
// TESTING (bench: wb_port_master port A -> memory_top, port B idle or second instance)
//  1 Write 0xFFFF0000 @0x80 sel=F, then read @0x80 -> one rsp per cmd, read rsp_data=0xFFFF0000,
//    CYC_O low after last ACK.
//  2 Four back-to-back writes @0x85..0x88 (0x12341234+i), no stall -> STB_O high 4 consecutive
//    cycles, 4 rsp pulses in order, outstanding never >4; readback matches.
//  3 Port A and B hit 0x70 same cycle (A write 0xDEADBEEF, B read) forcing STALL_I on one side ->
//    stalled master holds STB/ADDR/DATA stable until accepted; B eventually reads 0xDEADBEEF or prior value
//    consistent with slave arbitration order.
//  4 MAX_OUTSTANDING=2, slave model delays ACK 5 cycles -> cmd_ready=0 with 2 outstanding;
//    rises the cycle after first ACK.
//  5 Slave model never ACKs, TIMEOUT=64 -> CYC_O drops 64 cycles after accept, err one pulse,
//    outstanding=0, next command proceeds normally.
//  6 Assert rst=0 with 2 requests outstanding -> all outputs 0 within same cycle (async),
//    no rsp_valid/err after release; spurious ACK_I while idle -> err pulse, no rsp.

Source files
------------

// File: rtl/wb_port_master.sv
// Pipelined Wishbone B4 initiator: turns a valid/ready command stream into bus beats,
// tracks outstanding requests, returns ACKed data in order and aborts hung cycles.
module wb_port_master #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT         = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        err,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [7:0]  ADDR_O,
    output logic [31:0] DATA_O,
    output logic [3:0]  SEL_O,
    input  logic        STALL_I,
    input  logic        ACK_I,
    input  logic [31:0] DATA_I
);

    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StAbort} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [WdW-1:0]  wd_q, wd_d;
    logic            stb_q, stb_d;
    logic            we_q, we_d;
    logic [7:0]      addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic [3:0]      sel_q, sel_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            err_q, err_d;

    logic bus_accept, cmd_fire, ack_ok, wd_expire, abort;

    always_comb begin
        bus_accept = stb_q & ~STALL_I;
        ack_ok     = ACK_I & (state_q == StBusy) & (outstanding_q != '0);
        wd_expire  = (state_q == StBusy) & (outstanding_q != '0) & ~ACK_I & (wd_q == WdLast);
        // Refuse new work on the expiry cycle too, so nothing is accepted only to be dropped.
        abort      = (state_q == StAbort) | wd_expire;
        cmd_ready  = rst & (~stb_q | ~STALL_I)
                   & ((32'(outstanding_q) + 32'(stb_q)) < MAX_OUTSTANDING) & ~abort;
        cmd_fire   = cmd_valid & cmd_ready;
    end

    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q + CntW'(bus_accept) - CntW'(ack_ok);
        wd_d          = '0;
        stb_d         = stb_q;
        we_d          = we_q;
        addr_d        = addr_q;
        data_d        = data_q;
        sel_d         = sel_q;
        rsp_valid_d   = ack_ok;
        rsp_data_d    = ack_ok ? DATA_I : rsp_data_q;
        err_d         = ACK_I & ~ack_ok;

        if (cmd_fire) begin
            stb_d  = 1'b1;
            we_d   = cmd_we;
            addr_d = cmd_addr;
            data_d = cmd_data;
            sel_d  = cmd_sel;
        end else if (bus_accept) begin
            stb_d = 1'b0;
        end

        if ((state_q == StBusy) && (outstanding_q != '0) && !ACK_I) begin
            wd_d = wd_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_fire) state_d = StBusy;
            end
            StBusy: begin
                if (wd_expire) begin
                    state_d       = StAbort;
                    stb_d         = 1'b0;
                    outstanding_d = '0;
                    wd_d          = '0;
                    err_d         = 1'b1;
                end else if (!stb_d && (outstanding_d == '0)) begin
                    state_d = StIdle;
                end
            end
            StAbort: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            outstanding_q <= '0;
            wd_q          <= '0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            sel_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            wd_q          <= wd_d;
            stb_q         <= stb_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            sel_q         <= sel_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            err_q         <= err_d;
        end
    end

    assign CYC_O     = (state_q == StBusy);
    assign STB_O     = stb_q;
    assign WE_O      = we_q;
    assign ADDR_O    = addr_q;
    assign DATA_O    = data_q;
    assign SEL_O     = sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign err       = err_q;

endmodule
